ball_collision_scheduler: RTL and testbench
===========================================

BALL_COLLISION_SCHEDULER -- requirements
Module: ball_collision_scheduler

Interface
REQ-001 Parameter NUM_BALLS, default 8, number of balls (2..16).
REQ-002 Parameter ACK_TIMEOUT, default 15, max cycles waiting for resolveAck per pair.
REQ-003 clk  input  1  system clock.
REQ-004 resetN  input  1  reset, asynchronous, active-low.
REQ-005 startOfFrame  input  1  one-cycle pulse at frame start; closes the collection window.
REQ-006 ballDR  input  NUM_BALLS  per-ball pixel draw request for the current pixel.
REQ-007 ballActive  input  NUM_BALLS  1 = ball on table; 0 = pocketed, excluded from resolution.
REQ-008 resolveReq  output  1  request to the shared pairwise collision resolver.
REQ-009 resolveAck  input  1  resolver finished the presented pair (one-cycle pulse).
REQ-010 pairIdx1, pairIdx2  output  4 each  ball indices of the presented pair, pairIdx1 < pairIdx2.
REQ-011 busy  output  1  high while the state is not IDLE.
REQ-012 schedDone  output  1  one-cycle pulse when a frame's pair list is exhausted.
REQ-013 pairsResolved  output  8  pairs acknowledged in the last completed frame.
REQ-014 timeoutErr  output  1  sticky; set when any pair times out.
REQ-015 overrunErr  output  1  sticky; set when startOfFrame arrives while busy.

Function
REQ-016 Collection: every cycle, for each i<j, hit bit (i,j) SHALL be set when ballDR[i] && ballDR[j]; it runs in every state.
REQ-017 On startOfFrame in IDLE: copy the hit matrix into the pending matrix, clear the hit matrix, enter SCAN next cycle; hits in the same cycle go into the cleared (new) matrix.
REQ-018 On startOfFrame while busy: pending is not touched, hit matrix is not cleared, overrunErr is set.
REQ-019 States: IDLE, SCAN, REQ, DONE.
REQ-020 SCAN: one pair per cycle in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1), starting at (0,1).
REQ-021 SCAN: a pair that is pending with both balls active goes to REQ next cycle; a pending pair with either ball inactive is cleared and skipped.
REQ-022 REQ: resolveReq=1, with pairIdx1/2 held stable until it leaves REQ.
REQ-023 On resolveAck in REQ: the pending bit is cleared, the frame counter increments (saturating at 255), resolveReq drops the next cycle, and SCAN resumes at the following pair.
REQ-024 Timeout: ACK_TIMEOUT cycles in REQ without ack -> drop the pair (clear its bit, no count), set timeoutErr, resume SCAN.
REQ-025 resolveAck outside REQ SHALL be ignored.
REQ-026 After (N-2,N-1) is evaluated or dropped -> DONE; DONE lasts one cycle, pulses schedDone, loads pairsResolved from the frame counter, clears the frame counter, then returns to IDLE.
REQ-027 With an empty pending matrix, the frame takes exactly N(N-1)/2 SCAN cycles, then DONE.
REQ-028 Index arithmetic is unsigned 4-bit; no index reaches NUM_BALLS.

Reset
REQ-029 resetN low forces state IDLE and clears the hit and pending matrices, frame counter, timeout counter and both error flags.
REQ-030 Reset output values: resolveReq=0, pairIdx1=0, pairIdx2=1, busy=0, schedDone=0, pairsResolved=0, timeoutErr=0, overrunErr=0.
REQ-031 Reset asserted mid-REQ drops resolveReq asynchronously; no pair is resumed after reset.

Structure
REQ-032 The state enum, MAX_BALLS=16 and the index width (4) SHALL live in the shared billiard package.
REQ-033 The upper-triangular hit/pending storage and its (i,j) addressing SHALL be one sub-module, pair_matrix.
REQ-034 The existing pairwise velocity resolver connects as the resolveReq/resolveAck client, one pair at a time.

Verification
REQ-035 ballDR=0x05 for one cycle, then startOfFrame, ack 3 cycles after resolveReq -> exactly one request with pair (0,2); schedDone; pairsResolved=1.
REQ-036 Hits on (1,3) and (0,4), ack immediate -> requests in order (0,4) then (1,3); pairsResolved=2.
REQ-037 Hit (2,5) with ballActive[5]=0 -> no resolveReq; schedDone after 28 SCAN cycles (N=8); pairsResolved=0.
REQ-038 Hit (0,1) with ack never returned -> resolveReq high exactly 15 cycles; timeoutErr=1; pairsResolved=0.
REQ-039 startOfFrame while busy with ballDR=0x03 in the same cycle -> overrunErr=1; current pending is unchanged; (0,1) is resolved in the next frame.
REQ-040 resetN pulse while resolveReq=1 -> all outputs at reset values; the next frame with no hits gives pairsResolved=0.

Source files
------------

// File: rtl/ball_collision_scheduler_pkg.sv
// ball_collision_scheduler_pkg: shared billiard types and sizing.
// Holds the scheduler state enum, the maximum ball count and the ball index width.
package ball_collision_scheduler_pkg;
    localparam int MAX_BALLS = 16;
    localparam int IDX_W = 4;
    typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;
endpackage

// File: rtl/ball_collision_scheduler_pair_matrix.sv
// pair_matrix: upper-triangular hit/pending bit storage addressed by ball pair (i,j), i<j.
// Ports: clk, resetN (async, active-low); ballDR collects hits every cycle;
// snap copies hit->pending and restarts the hit matrix; clr clears pending (idx1,idx2);
// pend_bit reads pending (idx1,idx2).
module pair_matrix
    import ball_collision_scheduler_pkg::*;
#(
    parameter int NUM_BALLS = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NUM_BALLS-1:0] ballDR,
    input  logic                 snap,
    input  logic                 clr,
    input  logic [IDX_W-1:0]     idx1,
    input  logic [IDX_W-1:0]     idx2,
    output logic                 pend_bit
);
    logic [MAX_BALLS-1:0][MAX_BALLS-1:0] pend_m;

    assign pend_bit = pend_m[idx1][idx2];

    for (genvar i = 0; i < MAX_BALLS; i++) begin : g_row
        for (genvar j = 0; j < MAX_BALLS; j++) begin : g_col
            if (i < j && j < NUM_BALLS) begin : g_pair
                logic h, p;
                // A hit arriving in the snap cycle lands in the freshly cleared matrix.
                always_ff @(posedge clk or negedge resetN)
                    if (!resetN) begin
                        h <= 1'b0;
                        p <= 1'b0;
                    end else begin
                        h <= (h && !snap) || (ballDR[i] && ballDR[j]);
                        p <= snap ? h : p && !(clr && idx1 == IDX_W'(i) && idx2 == IDX_W'(j));
                    end
                assign pend_m[i][j] = p;
            end else begin : g_none
                assign pend_m[i][j] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/ball_collision_scheduler.sv
// ball_collision_scheduler: per-frame scheduler feeding ball pairs to a shared collision resolver.
// Ports: clk, resetN (async, active-low); startOfFrame closes the collection window;
// ballDR/ballActive per-ball draw request and on-table flags; resolveReq/resolveAck handshake
// with pairIdx1<pairIdx2; busy, schedDone pulse, pairsResolved of the last frame;
// sticky timeoutErr and overrunErr.
module ball_collision_scheduler
    import ball_collision_scheduler_pkg::*;
#(
    parameter int NUM_BALLS   = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_BALLS-1:0] ballDR,
    input  logic [NUM_BALLS-1:0] ballActive,
    output logic                 resolveReq,
    input  logic                 resolveAck,
    output logic [IDX_W-1:0]     pairIdx1,
    output logic [IDX_W-1:0]     pairIdx2,
    output logic                 busy,
    output logic                 schedDone,
    output logic [7:0]           pairsResolved,
    output logic                 timeoutErr,
    output logic                 overrunErr
);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    state_t state;
    logic [TW-1:0] tcnt;
    logic [7:0] fcnt;
    logic [MAX_BALLS-1:0] act_m;
    logic pend_bit, act, snap, clr, last, fin, adv;
    logic [IDX_W-1:0] nxt1, nxt2;

    assign act_m = MAX_BALLS'(ballActive);
    assign act   = act_m[pairIdx1] && act_m[pairIdx2];
    assign snap  = startOfFrame && state == IDLE;
    assign last  = pairIdx1 == LAST_I && pairIdx2 == LAST_J;
    // The pair in REQ finishes on ack or when its wait budget runs out; ack wins a tie.
    assign fin   = state == REQ && (resolveAck || tcnt == T_LAST);
    assign adv   = (state == SCAN && !(pend_bit && act)) || fin;
    assign clr   = (state == SCAN && pend_bit && !act) || fin;
    assign nxt1  = pairIdx2 == LAST_J ? pairIdx1 + 1'b1 : pairIdx1;
    assign nxt2  = pairIdx2 == LAST_J ? pairIdx1 + IDX_W'(2) : pairIdx2 + 1'b1;

    pair_matrix #(.NUM_BALLS(NUM_BALLS)) u_pair_matrix (
        .clk      (clk),
        .resetN   (resetN),
        .ballDR   (ballDR),
        .snap     (snap),
        .clr      (clr),
        .idx1     (pairIdx1),
        .idx2     (pairIdx2),
        .pend_bit (pend_bit)
    );

    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state         <= IDLE;
            resolveReq    <= 1'b0;
            pairIdx1      <= '0;
            pairIdx2      <= IDX_W'(1);
            busy          <= 1'b0;
            schedDone     <= 1'b0;
            pairsResolved <= '0;
            timeoutErr    <= 1'b0;
            overrunErr    <= 1'b0;
            tcnt          <= '0;
            fcnt          <= '0;
        end else begin
            if (startOfFrame && state != IDLE)
                overrunErr <= 1'b1;
            case (state)
                IDLE: if (startOfFrame) begin
                    state    <= SCAN;
                    busy     <= 1'b1;
                    pairIdx1 <= '0;
                    pairIdx2 <= IDX_W'(1);
                end
                SCAN: if (pend_bit && act) begin
                    state      <= REQ;
                    resolveReq <= 1'b1;
                    tcnt       <= '0;
                end
                REQ: if (fin) begin
                    resolveReq <= 1'b0;
                    if (resolveAck)
                        fcnt <= fcnt + {7'd0, fcnt != 8'hFF};
                    else
                        timeoutErr <= 1'b1;
                end else
                    tcnt <= tcnt + 1'b1;
                DONE: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    schedDone     <= 1'b0;
                    pairsResolved <= fcnt;
                    fcnt          <= '0;
                    pairIdx1      <= '0;
                    pairIdx2      <= IDX_W'(1);
                end
            endcase
            if (adv) begin
                if (last) begin
                    state     <= DONE;
                    schedDone <= 1'b1;
                end else begin
                    state    <= SCAN;
                    pairIdx1 <= nxt1;
                    pairIdx2 <= nxt2;
                end
            end
        end
endmodule

// File: tb/tb_ball_collision_scheduler.sv
// tb_ball_collision_scheduler: directed and randomized frames checked against a pair-set reference model.
module tb_ball_collision_scheduler;
    localparam int N = 8;
    localparam int TO = 15;
    localparam int NPAIR = N * (N - 1) / 2;

    logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, resolveAck = 1'b0;
    logic [N-1:0] ballDR = '0, ballActive = '1;
    logic resolveReq, busy, schedDone, timeoutErr, overrunErr;
    logic [3:0] pairIdx1, pairIdx2;
    logic [7:0] pairsResolved;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    ball_collision_scheduler #(.NUM_BALLS(N), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
        .ballActive(ballActive), .resolveReq(resolveReq), .resolveAck(resolveAck),
        .pairIdx1(pairIdx1), .pairIdx2(pairIdx2), .busy(busy), .schedDone(schedDone),
        .pairsResolved(pairsResolved), .timeoutErr(timeoutErr), .overrunErr(overrunErr)
    );

    // Reference model: sets of colliding pairs, frame outcome from the scheduling rules.
    bit mhit[N][N], mpend[N][N];
    bit exp_terr, exp_ovr;
    logic [223:0] exp_pack;
    int exp_n, exp_pr, exp_reqcyc;

    // Stimulus for one frame.
    logic [N-1:0] pre_q[$];
    logic [N-1:0] sof_dr, inject_dr;
    int lat_q[$];
    int inject_cyc;
    bit spur;

    // Observations of one frame.
    logic [223:0] obs_pack;
    int obs_n, obs_scan, obs_reqcyc, obs_done, obs_unstable;
    logic [7:0] obs_pr;
    logic obs_busy;

    function automatic int get_lat(int k);
        return k < lat_q.size() ? lat_q[k] : 0;
    endfunction

    task automatic model_reset();
        foreach (mhit[a, b]) begin mhit[a][b] = 0; mpend[a][b] = 0; end
        exp_terr = 0;
        exp_ovr = 0;
    endtask

    task automatic model_collect(input logic [N-1:0] dr);
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (dr[a] && dr[b]) mhit[a][b] = 1;
    endtask

    task automatic model_sof();
        int l;
        mpend = mhit;
        foreach (mhit[a, b]) mhit[a][b] = 0;
        exp_pack = '0; exp_n = 0; exp_pr = 0; exp_reqcyc = 0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (mpend[a][b] && ballActive[a] && ballActive[b]) begin
                    l = get_lat(exp_n);
                    exp_pack = {exp_pack[215:0], 4'(a), 4'(b)};
                    exp_n++;
                    if (l < TO) begin exp_pr++; exp_reqcyc += l + 1; end
                    else begin exp_terr = 1; exp_reqcyc += TO; end
                end
    endtask

    task automatic setup(input logic [N-1:0] act);
        pre_q.delete(); lat_q.delete();
        sof_dr = '0; inject_dr = '0; inject_cyc = -1; spur = 0;
        ballActive = act;
    endtask

    // Drives one frame and acts as the resolver; bounded so a stuck DUT still returns.
    task automatic run_frame();
        bit fin = 0, prev_req = 0;
        int wait_k = 0;
        logic [7:0] cur = '0;
        obs_pack = '0; obs_n = 0; obs_scan = 0; obs_reqcyc = 0; obs_done = 0; obs_unstable = 0;
        obs_pr = 'x; obs_busy = 'x;
        foreach (pre_q[k]) begin
            @(negedge clk); ballDR = pre_q[k]; model_collect(pre_q[k]);
        end
        @(negedge clk); startOfFrame = 1; ballDR = sof_dr;
        model_sof(); model_collect(sof_dr);
        @(negedge clk); startOfFrame = 0; ballDR = '0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            startOfFrame = 0; ballDR = '0; resolveAck = 0;
            if (schedDone) begin
                obs_done++;
                @(negedge clk);
                obs_pr = pairsResolved; obs_busy = busy; fin = 1;
            end else begin
                if (resolveReq) begin
                    if (!prev_req) begin
                        cur = {pairIdx1, pairIdx2};
                        obs_pack = {obs_pack[215:0], cur};
                        wait_k = get_lat(obs_n);
                        obs_n++;
                    end else if ({pairIdx1, pairIdx2} !== cur) obs_unstable++;
                    obs_reqcyc++;
                    if (wait_k == 0) resolveAck = 1;
                    wait_k--;
                end else if (busy) begin
                    obs_scan++;
                    if (spur && $urandom_range(0, 3) == 0) resolveAck = 1;
                end
                if (c == inject_cyc) begin
                    startOfFrame = 1; ballDR = inject_dr;
                    model_collect(inject_dr); exp_ovr = 1;
                end
                prev_req = resolveReq;
                @(negedge clk);
            end
        end
        resolveAck = 0; startOfFrame = 0; ballDR = '0;
    endtask

    task automatic test_reset();
        resetN = 0; startOfFrame = 0; ballDR = '0; resolveAck = 0; ballActive = '1;
        repeat (3) @(negedge clk);
        checks++; if (resolveReq !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", resolveReq); end
        checks++; if (pairIdx1 !== 4'd0) begin failures++; $display("FAIL reset_idx1 got %0d want 0", pairIdx1); end
        checks++; if (pairIdx2 !== 4'd1) begin failures++; $display("FAIL reset_idx2 got %0d want 1", pairIdx2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (schedDone !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", schedDone); end
        checks++; if (pairsResolved !== 8'd0) begin failures++; $display("FAIL reset_pr got %0d want 0", pairsResolved); end
        checks++; if (timeoutErr !== 1'b0) begin failures++; $display("FAIL reset_terr got %b want 0", timeoutErr); end
        checks++; if (overrunErr !== 1'b0) begin failures++; $display("FAIL reset_ovr got %b want 0", overrunErr); end
        resetN = 1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        setup('1); pre_q = '{8'h05}; lat_q = '{3};
        run_frame();
        checks++; if (obs_n !== 1) begin failures++; $display("FAIL single_n got %0d want 1", obs_n); end
        checks++; if (obs_pack !== 224'h02) begin failures++; $display("FAIL single_pair got %0h want 02", obs_pack); end
        checks++; if (obs_reqcyc !== 4) begin failures++; $display("FAIL single_reqcyc got %0d want 4", obs_reqcyc); end
        checks++; if (obs_scan !== NPAIR) begin failures++; $display("FAIL single_scan got %0d want %0d", obs_scan, NPAIR); end
        checks++; if (obs_done !== 1) begin failures++; $display("FAIL single_done got %0d want 1", obs_done); end
        checks++; if (obs_pr !== 8'd1) begin failures++; $display("FAIL single_pr got %0d want 1", obs_pr); end
        checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL single_busy got %b want 0", obs_busy); end
    endtask

    task automatic test_order();
        setup('1); pre_q = '{8'h0A, 8'h11}; lat_q = '{0, 0}; spur = 1;
        run_frame();
        checks++; if (obs_pack !== 224'h0413) begin failures++; $display("FAIL order_pairs got %0h want 0413", obs_pack); end
        checks++; if (obs_pr !== 8'd2) begin failures++; $display("FAIL order_pr got %0d want 2", obs_pr); end
        checks++; if (obs_reqcyc !== 2) begin failures++; $display("FAIL order_reqcyc got %0d want 2", obs_reqcyc); end
    endtask

    task automatic test_ack_edge();
        setup('1); pre_q = '{8'h03}; lat_q = '{TO - 1};
        run_frame();
        checks++; if (obs_reqcyc !== TO) begin failures++; $display("FAIL edge_reqcyc got %0d want %0d", obs_reqcyc, TO); end
        checks++; if (obs_pr !== 8'd1) begin failures++; $display("FAIL edge_pr got %0d want 1", obs_pr); end
        checks++; if (timeoutErr !== 1'b0) begin failures++; $display("FAIL edge_terr got %b want 0", timeoutErr); end
    endtask

    task automatic test_inactive();
        setup(8'hDF); pre_q = '{8'h24};
        run_frame();
        checks++; if (obs_n !== 0) begin failures++; $display("FAIL inact_n got %0d want 0", obs_n); end
        checks++; if (obs_scan !== NPAIR) begin failures++; $display("FAIL inact_scan got %0d want %0d", obs_scan, NPAIR); end
        checks++; if (obs_pr !== 8'd0) begin failures++; $display("FAIL inact_pr got %0d want 0", obs_pr); end
    endtask

    task automatic test_timeout();
        setup('1); pre_q = '{8'h03}; lat_q = '{255};
        run_frame();
        checks++; if (obs_n !== 1) begin failures++; $display("FAIL tmo_n got %0d want 1", obs_n); end
        checks++; if (obs_reqcyc !== TO) begin failures++; $display("FAIL tmo_reqcyc got %0d want %0d", obs_reqcyc, TO); end
        checks++; if (timeoutErr !== 1'b1) begin failures++; $display("FAIL tmo_terr got %b want 1", timeoutErr); end
        checks++; if (obs_pr !== 8'd0) begin failures++; $display("FAIL tmo_pr got %0d want 0", obs_pr); end
    endtask

    task automatic test_overrun();
        setup('1); pre_q = '{8'h0C}; lat_q = '{5}; inject_cyc = 3; inject_dr = 8'h03;
        run_frame();
        checks++; if (overrunErr !== 1'b1) begin failures++; $display("FAIL ovr_flag got %b want 1", overrunErr); end
        checks++; if (obs_pack !== 224'h23) begin failures++; $display("FAIL ovr_pairs got %0h want 23", obs_pack); end
        checks++; if (obs_pr !== 8'd1) begin failures++; $display("FAIL ovr_pr got %0d want 1", obs_pr); end
        setup('1);
        run_frame();
        checks++; if (obs_pack !== 224'h01) begin failures++; $display("FAIL ovr_next got %0h want 01", obs_pack); end
        checks++; if (obs_pr !== 8'd1) begin failures++; $display("FAIL ovr_next_pr got %0d want 1", obs_pr); end
    endtask

    task automatic test_random();
        logic [N-1:0] d;
        for (int f = 0; f < 10; f++) begin
            setup(N'($urandom) | N'($urandom) | N'($urandom));
            spur = 1;
            for (int p = 0; p < $urandom_range(1, 4); p++) begin
                d = '0;
                for (int q = 0; q < $urandom_range(2, 3); q++) d[$urandom_range(0, N - 1)] = 1'b1;
                pre_q.push_back(d);
            end
            if ($urandom_range(0, 1) == 1) sof_dr = N'($urandom) & N'($urandom);
            for (int k = 0; k < NPAIR; k++)
                lat_q.push_back($urandom_range(0, 9) == 0 ? 255 : $urandom_range(0, TO - 1));
            run_frame();
            checks++; if (obs_pack !== exp_pack) begin failures++; $display("FAIL rnd%0d_pairs got %0h want %0h", f, obs_pack, exp_pack); end
            checks++; if (obs_n !== exp_n) begin failures++; $display("FAIL rnd%0d_n got %0d want %0d", f, obs_n, exp_n); end
            checks++; if (obs_pr !== 8'(exp_pr)) begin failures++; $display("FAIL rnd%0d_pr got %0d want %0d", f, obs_pr, exp_pr); end
            checks++; if (obs_reqcyc !== exp_reqcyc) begin failures++; $display("FAIL rnd%0d_reqcyc got %0d want %0d", f, obs_reqcyc, exp_reqcyc); end
            checks++; if (obs_scan !== NPAIR) begin failures++; $display("FAIL rnd%0d_scan got %0d want %0d", f, obs_scan, NPAIR); end
            checks++; if (obs_done !== 1) begin failures++; $display("FAIL rnd%0d_done got %0d want 1", f, obs_done); end
            checks++; if (obs_unstable !== 0) begin failures++; $display("FAIL rnd%0d_stable got %0d want 0", f, obs_unstable); end
            checks++; if (timeoutErr !== exp_terr) begin failures++; $display("FAIL rnd%0d_terr got %b want %b", f, timeoutErr, exp_terr); end
            checks++; if (overrunErr !== exp_ovr) begin failures++; $display("FAIL rnd%0d_ovr got %b want %b", f, overrunErr, exp_ovr); end
        end
    endtask

    task automatic test_reset_mid();
        setup('1);
        @(negedge clk); ballDR = 8'h03;
        @(negedge clk); ballDR = '0; startOfFrame = 1;
        @(negedge clk); startOfFrame = 0;
        for (int c = 0; c < 50 && !resolveReq; c++) @(negedge clk);
        checks++; if (resolveReq !== 1'b1) begin failures++; $display("FAIL mid_reqwait got %b want 1", resolveReq); end
        #2 resetN = 0;
        #1;
        checks++; if (resolveReq !== 1'b0) begin failures++; $display("FAIL mid_req got %b want 0", resolveReq); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if ({pairIdx1, pairIdx2} !== 8'h01) begin failures++; $display("FAIL mid_idx got %0h want 01", {pairIdx1, pairIdx2}); end
        checks++; if ({timeoutErr, overrunErr} !== 2'b00) begin failures++; $display("FAIL mid_errs got %b want 00", {timeoutErr, overrunErr}); end
        checks++; if (pairsResolved !== 8'd0) begin failures++; $display("FAIL mid_pr got %0d want 0", pairsResolved); end
        @(negedge clk); resetN = 1;
        model_reset();
        run_frame();
        checks++; if (obs_n !== 0) begin failures++; $display("FAIL mid_next_n got %0d want 0", obs_n); end
        checks++; if (obs_pr !== 8'd0) begin failures++; $display("FAIL mid_next_pr got %0d want 0", obs_pr); end
        checks++; if (obs_done !== 1) begin failures++; $display("FAIL mid_next_done got %0d want 1", obs_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_ack_edge();
        test_inactive();
        test_timeout();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule
